// File: rtl/micro_ondas_ctrl.sv
// Microwave-oven controller.
// Holds a BCD seconds countdown, duty-cycles the heater over a CICLO_POT-second
// window, pauses while the door is open, and beeps for SOM_SEG seconds at the end.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   t        BCD cooking time, digit 0 (units) in t[3:0]
//   conf     start/resume/acknowledge key (level; rising edge detected here)
//   cancela  cancel key (level)
//   r        power level 0..15 (heater on r seconds per window)
//   porta    door open = 1
//   leds     seven-segment outputs, digit i in leds[7i+6:7i], bit0 = seg a
//   luz      cavity lamp
//   motor    turntable motor
//   aquec    heater enable
//   som      buzzer
//   estado   current state code
module micro_ondas_ctrl #(
  parameter int unsigned DIGITOS   = 4,
  parameter int unsigned TICKS_SEG = 1000,
  parameter int unsigned CICLO_POT = 10,
  parameter int unsigned SOM_SEG   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*DIGITOS-1:0] t,
  input  logic                 conf,
  input  logic                 cancela,
  input  logic [3:0]           r,
  input  logic                 porta,
  output logic [7*DIGITOS-1:0] leds,
  output logic                 luz,
  output logic                 motor,
  output logic                 aquec,
  output logic                 som,
  output logic [1:0]           estado
);

  localparam int unsigned PreW  = (TICKS_SEG > 1) ? $clog2(TICKS_SEG) : 1;
  localparam int unsigned PosW  = (CICLO_POT > 1) ? $clog2(CICLO_POT) : 1;
  localparam int unsigned BeepW = (SOM_SEG > 0) ? $clog2(SOM_SEG + 1) : 1;
  localparam int unsigned CntW  = 4 * DIGITOS;
  localparam int unsigned LedW  = 7 * DIGITOS;

  localparam logic [1:0] OCIOSO    = 2'b00;
  localparam logic [1:0] AQUECENDO = 2'b01;
  localparam logic [1:0] PAUSA     = 2'b10;
  localparam logic [1:0] FIM       = 2'b11;

  // Seven-segment pattern for one BCD digit; non-decimal codes are blanked.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [LedW-1:0] disp(input logic [CntW-1:0] v);
    logic [LedW-1:0] o;
    o = '0;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      o[7*i +: 7] = seg7(v[4*i +: 4]);
    end
    return o;
  endfunction

  // Every digit decimal and the total non-zero.
  function automatic logic bcd_valid(input logic [CntW-1:0] v);
    logic ok;
    ok = (v != '0);
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Decrement by one second; a zero digit wraps to 9 and borrows from the next.
  function automatic logic [CntW-1:0] bcd_dec(input logic [CntW-1:0] v);
    logic [CntW-1:0] o;
    logic            borrow;
    o      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITOS); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          o[4*i +: 4] = 4'd9;
        end else begin
          o[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return o;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [BeepW-1:0] beep_q, beep_d;
  logic             conf_q;
  logic             porta_q;

  logic [LedW-1:0]  leds_q, leds_d;
  logic             luz_q, luz_d;
  logic             motor_q, motor_d;
  logic             aquec_q, aquec_d;
  logic             som_q, som_d;
  logic [1:0]       estado_q;

  logic             conf_ed;
  logic             porta_re;
  logic             t_valida;
  logic             counting;
  logic             tick;
  logic [CntW-1:0]  cnt_dec;
  logic [BeepW-1:0] beep_inc;

  assign conf_ed  = conf & ~conf_q;
  assign porta_re = porta & ~porta_q;
  assign t_valida = bcd_valid(t);
  assign counting = (state_q == AQUECENDO) || (state_q == FIM);
  assign tick     = counting && (pre_q == PreW'(TICKS_SEG - 1));
  assign cnt_dec  = bcd_dec(cnt_q);
  assign beep_inc = beep_q + BeepW'(1);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    beep_d  = beep_q;
    pre_d   = pre_q;

    // The prescaler runs in every AQUECENDO/FIM cycle, including one that leaves the state.
    if (counting) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
    end

    case (state_q)
      OCIOSO: begin
        if (conf_ed && !porta && t_valida) begin
          state_d = AQUECENDO;
          cnt_d   = t;
          pos_d   = '0;
          pre_d   = '0;
        end
      end
      AQUECENDO: begin
        if (cancela) begin
          state_d = OCIOSO;
        end else if (porta) begin
          // Door beats a simultaneous tick: no decrement this cycle.
          state_d = PAUSA;
        end else if (tick) begin
          cnt_d = cnt_dec;
          pos_d = (pos_q == PosW'(CICLO_POT - 1)) ? '0 : pos_q + PosW'(1);
          if (cnt_dec == '0) begin
            state_d = FIM;
            beep_d  = '0;
          end
        end
      end
      PAUSA: begin
        if (cancela) begin
          state_d = OCIOSO;
        end else if (conf_ed && !porta) begin
          state_d = AQUECENDO;
        end
      end
      FIM: begin
        if (conf_ed || cancela || porta_re) begin
          state_d = OCIOSO;
        end else if (tick) begin
          beep_d = beep_inc;
          if (beep_inc == BeepW'(SOM_SEG)) begin
            state_d = OCIOSO;
          end
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  // Output decode from the current state; registered below, so outputs lag by one cycle.
  always_comb begin
    leds_d  = '0;
    luz_d   = 1'b0;
    motor_d = 1'b0;
    aquec_d = 1'b0;
    som_d   = 1'b0;
    case (state_q)
      OCIOSO: begin
        luz_d  = porta;
        leds_d = disp(t);
      end
      AQUECENDO: begin
        luz_d   = 1'b1;
        motor_d = 1'b1;
        aquec_d = 32'(pos_q) < 32'(r);
        leds_d  = disp(cnt_q);
      end
      PAUSA: begin
        luz_d  = 1'b1;
        leds_d = disp(cnt_q);
      end
      FIM: begin
        som_d  = 1'b1;
        leds_d = disp('0);
      end
      default: leds_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      pre_q    <= '0;
      pos_q    <= '0;
      beep_q   <= '0;
      conf_q   <= 1'b0;
      porta_q  <= 1'b0;
      leds_q   <= '0;
      luz_q    <= 1'b0;
      motor_q  <= 1'b0;
      aquec_q  <= 1'b0;
      som_q    <= 1'b0;
      estado_q <= OCIOSO;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      pos_q    <= pos_d;
      beep_q   <= beep_d;
      conf_q   <= conf;
      porta_q  <= porta;
      leds_q   <= leds_d;
      luz_q    <= luz_d;
      motor_q  <= motor_d;
      aquec_q  <= aquec_d;
      som_q    <= som_d;
      estado_q <= state_q;
    end
  end

  assign leds   = leds_q;
  assign luz    = luz_q;
  assign motor  = motor_q;
  assign aquec  = aquec_q;
  assign som    = som_q;
  assign estado = estado_q;

endmodule

// File: tb/tb_micro_ondas_ctrl.sv
// Self-checking bench for micro_ondas_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a seconds-level behavioural model.
module tb_micro_ondas_ctrl;

  localparam int Dig = 4;
  localparam int Tk  = 4;
  localparam int Cp  = 10;
  localparam int Ss  = 3;

  logic        clk = 1'b0;
  logic        rst, conf, cancela, porta;
  logic [15:0] t;
  logic [3:0]  r;
  logic [27:0] leds;
  logic        luz, motor, aquec, som;
  logic [1:0]  estado;

  always #5 clk = ~clk;

  micro_ondas_ctrl #(
    .DIGITOS  (Dig),
    .TICKS_SEG(Tk),
    .CICLO_POT(Cp),
    .SOM_SEG  (Ss)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .t      (t),
    .conf   (conf),
    .cancela(cancela),
    .r      (r),
    .porta  (porta),
    .leds   (leds),
    .luz    (luz),
    .motor  (motor),
    .aquec  (aquec),
    .som    (som),
    .estado (estado)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (seconds as plain integers) ----------------
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] seg_of(input int d);
    return (d <= 9) ? seg_tab[d] : 7'h00;
  endfunction

  function automatic logic [27:0] show_nibbles(input logic [15:0] v);
    logic [27:0] o;
    for (int i = 0; i < Dig; i++) o[7*i +: 7] = seg_of(int'(v[4*i +: 4]));
    return o;
  endfunction

  function automatic logic [27:0] show_secs(input int n);
    logic [27:0] o;
    int          x;
    x = n;
    for (int i = 0; i < Dig; i++) begin
      o[7*i +: 7] = seg_of(x % 10);
      x = x / 10;
    end
    return o;
  endfunction

  function automatic bit time_ok(input logic [15:0] v);
    bit ok;
    ok = (v != 16'h0);
    for (int i = 0; i < Dig; i++) if (v[4*i +: 4] > 4'd9) ok = 0;
    return ok;
  endfunction

  function automatic int secs_of(input logic [15:0] v);
    int s;
    int w;
    s = 0;
    w = 1;
    for (int i = 0; i < Dig; i++) begin
      s = s + int'(v[4*i +: 4]) * w;
      w = w * 10;
    end
    return s;
  endfunction

  // 0 idle, 1 heating, 2 paused, 3 beeping
  int          m_st, m_secs, m_sub, m_win, m_beep;
  bit          m_conf_q, m_porta_q;
  logic [1:0]  e_st;
  logic [27:0] e_leds;
  logic [3:0]  e_outs;  // {luz, motor, aquec, som}

  task automatic model_step();
    bit conf_ev, door_ev, sec_end;
    if (rst) begin
      m_st = 0; m_secs = 0; m_sub = 0; m_win = 0; m_beep = 0;
      m_conf_q = 0; m_porta_q = 0;
      e_st = 2'd0; e_leds = '0; e_outs = 4'b0000;
      return;
    end
    e_st = 2'(m_st);
    case (m_st)
      0: begin e_outs = {porta, 3'b000};            e_leds = show_nibbles(t); end
      1: begin e_outs = {2'b11, m_win < int'(r), 1'b0}; e_leds = show_secs(m_secs); end
      2: begin e_outs = 4'b1000;                   e_leds = show_secs(m_secs); end
      default: begin e_outs = 4'b0001;             e_leds = show_secs(0); end
    endcase
    conf_ev = conf && !m_conf_q;
    door_ev = porta && !m_porta_q;
    sec_end = (m_st == 1 || m_st == 3) && (m_sub == Tk - 1);
    if (m_st == 1 || m_st == 3) m_sub = (m_sub + 1) % Tk;
    case (m_st)
      0: if (conf_ev && !porta && time_ok(t)) begin
        m_st = 1; m_secs = secs_of(t); m_win = 0; m_sub = 0;
      end
      1: begin
        if (cancela) m_st = 0;
        else if (porta) m_st = 2;
        else if (sec_end) begin
          m_secs = m_secs - 1;
          m_win  = (m_win + 1) % Cp;
          if (m_secs == 0) begin m_st = 3; m_beep = 0; end
        end
      end
      2: begin
        if (cancela) m_st = 0;
        else if (conf_ev && !porta) m_st = 1;
      end
      default: begin
        if (conf_ev || cancela || door_ev) m_st = 0;
        else if (sec_end) begin
          m_beep++;
          if (m_beep == Ss) m_st = 0;
        end
      end
    endcase
    m_conf_q  = conf;
    m_porta_q = porta;
  endtask

  // ---------------- stepping and observation counters ----------------
  int         n_motor, n_som, n_run, n_aq, n_start;
  logic [1:0] prev_est = 2'd0;

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("estado", 32'(estado), 32'(e_st));
    check("leds", 32'(leds), 32'(e_leds));
    check("luz_motor_aquec_som", 32'({luz, motor, aquec, som}), 32'(e_outs));
    if (motor) n_motor++;
    if (som) n_som++;
    if (aquec) n_aq++;
    if (estado == 2'd1) n_run++;
    if (estado == 2'd1 && prev_est == 2'd0) n_start++;
    prev_est = estado;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    n_motor = 0; n_som = 0; n_run = 0; n_aq = 0; n_start = 0;
  endtask

  task automatic pulse_conf();
    conf = 1'b1;
    step();
    conf = 1'b0;
    step();
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && estado != 2'd0; k++) step();
    check("idle_reached", 32'(estado), 32'd0);
  endtask

  function automatic logic [15:0] rand_time();
    int n;
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'($urandom);
      2: return 16'h0100;
      default: begin
        n = $urandom_range(1, 25);
        return {8'h00, 4'(n / 10), 4'(n % 10)};
      end
    endcase
  endfunction

  initial begin
    rst = 1'b1; conf = 1'b0; cancela = 1'b0; porta = 1'b0; t = 16'h0; r = 4'd0;
    clear_counts();
    steps(2);
    check("reset_outputs", 32'({estado, leds, luz, motor, aquec, som}), 32'd0);
    rst = 1'b0;

    // Basic run: 12 s at full power.
    t = 16'h0012; r = 4'd10;
    step();
    clear_counts();
    pulse_conf();
    check("start_estado", 32'(estado), 32'd1);
    check("start_lamp_motor_heat", 32'({luz, motor, aquec}), 32'b111);
    check("start_leds", 32'(leds[13:0]), 32'({7'h06, 7'h5B}));
    wait_idle(300);
    check("run_cycles", 32'(n_run), 32'd48);
    check("beep_cycles", 32'(n_som), 32'd12);

    // Borrow across digits and 3/10 duty.
    t = 16'h0100; r = 4'd3;
    step();
    clear_counts();
    pulse_conf();
    steps(4);
    check("borrow_0099", 32'(leds), 32'({7'h3F, 7'h3F, 7'h6F, 7'h6F}));
    steps(75);
    check("duty_on_cycles", 32'(n_aq), 32'd24);
    cancela = 1'b1; step(); cancela = 1'b0;
    wait_idle(10);

    // Door opened mid-second, reopened key ignored, resume.
    t = 16'h0005; r = 4'd10;
    step();
    clear_counts();
    pulse_conf();
    steps(5);
    porta = 1'b1;
    step();
    steps(2);
    check("pause_outputs", 32'({estado, luz, motor, aquec}), 32'({2'd2, 3'b100}));
    pulse_conf();
    check("pause_conf_ignored", 32'(estado), 32'd2);
    porta = 1'b0;
    step();
    pulse_conf();
    wait_idle(300);
    check("heat_cycles", 32'(n_motor), 32'd20);

    // Rejected starts.
    porta = 1'b1; t = 16'h0003;
    pulse_conf(); steps(2);
    check("reject_door", 32'(estado), 32'd0);
    porta = 1'b0; t = 16'h00A5;
    pulse_conf(); steps(2);
    check("reject_hex", 32'(estado), 32'd0);
    check("blank_digit", 32'(leds[13:7]), 32'd0);
    t = 16'h0000;
    pulse_conf(); steps(2);
    check("reject_zero", 32'(estado), 32'd0);

    // Held key starts only once.
    t = 16'h0003;
    step();
    clear_counts();
    conf = 1'b1;
    steps(10);
    conf = 1'b0;
    wait_idle(200);
    check("one_start", 32'(n_start), 32'd1);

    // Cancel outranks door.
    t = 16'h0009; r = 4'd5;
    pulse_conf();
    steps(3);
    cancela = 1'b1; porta = 1'b1;
    step();
    cancela = 1'b0; porta = 1'b0;
    step();
    check("cancel_over_door", 32'(estado), 32'd0);

    // Reset during the beep.
    t = 16'h0001;
    pulse_conf();
    for (int k = 0; k < 200 && estado != 2'd3; k++) step();
    check("reach_fim", 32'(estado), 32'd3);
    rst = 1'b1;
    step();
    check("rst_in_fim", 32'({estado, leds, luz, motor, aquec, som}), 32'd0);
    rst = 1'b0;

    // Random traffic.
    for (int c = 0; c < 20000; c++) begin
      conf    = ($urandom_range(0, 9) < 2);
      cancela = ($urandom % 150 == 0);
      rst     = ($urandom % 1000 == 0);
      if ($urandom % 40 == 0) porta = ~porta;
      if ($urandom % 100 == 0) r = 4'($urandom);
      if ($urandom % 50 == 0) t = rand_time();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_ondas_ctrl.md
Name: micro_ondas_ctrl

Overview:
Clocked, parametrised microwave-oven controller. Supersedes the combinational time/door/power front end: it holds a BCD seconds countdown, sets heater power by duty-cycling, and pauses when the door opens. It drives DIGITOS seven-segment displays, lamp, turntable motor, heater and buzzer. It sits directly under the board top level, between the keypad/switch inputs and the display and actuator pins.

Parameters:
DIGITOS, 4, number of BCD digits in the time entry, the countdown and the displays.
TICKS_SEG, 1000, clk cycles per one-second tick (1 kHz clk).
CICLO_POT, 10, length in seconds of the heater duty window.
SOM_SEG, 3, length in seconds of the end-of-cycle beep.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
t  in  4*DIGITOS  BCD cooking time in seconds; digit 0 = t[3:0] = units
conf  in  1  start/resume/acknowledge key; level input, rising edge detected internally
cancela  in  1  cancel key, level-sensitive
r  in  4  power level 0..15; heater on for r seconds of each CICLO_POT window
porta  in  1  door open = 1
leds  out  7*DIGITOS  seven-segment outputs; leds[7i+6:7i] = digit i; bit0 = seg a .. bit6 = seg g; active-high
luz  out  1  cavity lamp
motor  out  1  turntable motor
aquec  out  1  heater/magnetron enable
som  out  1  buzzer
estado  out  2  current state code (debug/verification)

Behaviour:
- One clock, reset is synchronous and active-high. All outputs are registered and follow the state/counter with 1 cycle of latency.
- Reset: state=OCIOSO(00); countdown, prescaler, duty position and beep counter = 0; conf edge register = 0; all outputs = 0, including leds.
- conf edge: conf_ed = conf & ~conf_q. conf_q is registered each cycle. Holding conf high produces only one event.
- t_valida: every digit of t is <= 9 and t != 0.
- Tick: the prescaler counts 0..TICKS_SEG-1 only in AQUECENDO or FIM. tick=1 in the cycle it wraps. The prescaler is cleared on OCIOSO->AQUECENDO and held (not cleared) in PAUSA.
- OCIOSO(00):
  - luz=porta; motor=aquec=som=0; leds show t.
  - conf_ed & ~porta & t_valida -> load countdown=t, duty position=0, go AQUECENDO.
  - Otherwise stay. An invalid t is ignored silently.
- AQUECENDO(01):
  - luz=1, motor=1, aquec=(pos<r); leds show countdown.
  - On tick: BCD decrement with borrow across digits (x0 -> 9 with borrow); pos=(pos==CICLO_POT-1)?0:pos+1.
  - If the countdown after decrement is 0 -> FIM.
  - Priority, highest first: rst > cancela (-> OCIOSO) > porta (-> PAUSA) > tick.
  - porta and tick in the same cycle: go to PAUSA, no decrement.
- PAUSA(10):
  - luz=1, motor=aquec=som=0; countdown, prescaler and pos are frozen; leds show countdown.
  - cancela -> OCIOSO.
  - conf_ed & ~porta -> AQUECENDO, resuming at the same prescaler value.
  - conf_ed while porta=1 is ignored.
- FIM(11):
  - som=1, motor=aquec=0, luz=0; leds show all zeros.
  - Beep counter increments on tick. When it reaches SOM_SEG -> OCIOSO.
  - conf_ed, cancela or a porta rising edge ends the beep early -> OCIOSO next cycle.
- Seven-segment decode:
  - 0..9 use standard patterns: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F.
  - Digit > 9 = blank (7'h00).
- r >= CICLO_POT: heater on continuously. r=0: heater never on, but motor and countdown still run.
- r and t are sampled live. t matters only in OCIOSO; r changes take effect at the next cycle.
- rst mid-operation returns to the reset values on the next edge regardless of state.
- Width rules: prescaler width = clog2(TICKS_SEG); pos width = clog2(CICLO_POT); beep counter width = clog2(SOM_SEG+1).

Test Plan:
- Bench parameters for all scenarios: TICKS_SEG=4, DIGITOS=4, CICLO_POT=10, SOM_SEG=3.
- Basic run: t=16'h0012, r=10, porta=0, pulse conf. Required: estado=01 and motor=aquec=luz=1 one cycle later. leds digits 1,0 = 7'h06, 7'h5B. After 12 ticks (48 cycles) estado=11, som=1 for 12 cycles, then estado=00.
- Borrow and duty: t=16'h0100, r=3. Required: after 1 tick countdown=0099. aquec=1 for the first 12 cycles of each 40-cycle window, 0 for the remaining 28.
- Door pause/resume: during a t=0005 run, set porta=1 mid-second. Required: next state PAUSA, motor=aquec=0, luz=1, countdown frozen. porta=0 plus conf pulse resumes; total heating cycles = 20.
- Rejects: conf with porta=1, or t=16'h00A5, or t=0. Required: estado stays 00 and leds show the blank digit for the A nibble. Holding conf high for 10 cycles gives exactly one start.
- Cancel/reset priority: cancela and porta asserted in the same cycle in AQUECENDO -> OCIOSO. rst asserted in FIM -> all outputs 0 on the next edge, estado=00.
